// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with optional even parity
//
// Purpose: serialises one byte per request as start(0), data LSB first,
//          optional even parity, stop(1); each bit lasts CLK_FREQ/UART_BPS clocks.
// Config : define UART_TX_PARITY_EN to insert an even parity bit (11-bit frame).
// Ports  :
//   clk          - clock, all logic on rising edge
//   rst_n        - asynchronous active-low reset
//   uart_tx_en   - single-cycle transmit request (accepted only when idle)
//   uart_tx_data - byte to send, sampled with uart_tx_en
//   uart_txd     - registered serial line, idle high
//   uart_tx_busy - high while a frame is in progress
//   uart_tx_done - one-cycle pulse after the stop bit completes
module uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_txd,
    output logic       uart_tx_busy,
    output logic       uart_tx_done
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  data_reg;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;

    // Line level for frame bit position idx (0 = start bit).
    function automatic logic bit_value(input logic [3:0] idx, input logic [7:0] d);
        logic v;
        v = 1'b1;
        if (idx == 4'd0) begin
            v = 1'b0;
        end else if (idx <= 4'd8) begin
            v = d[3'(idx - 4'd1)];
        end
`ifdef UART_TX_PARITY_EN
        else if (idx == 4'd9) begin
            v = ^d;
        end
`endif
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            data_reg     <= 8'd0;
            baud_cnt     <= 16'd0;
            bit_cnt      <= 4'd0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
            uart_tx_done <= 1'b0;
        end else begin
            uart_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    bit_cnt  <= 4'd0;
                    uart_txd <= 1'b1;
                    if (uart_tx_en) begin
                        data_reg     <= uart_tx_data;
                        state        <= SEND;
                        uart_tx_busy <= 1'b1;
                        // Start bit appears on the very first SEND cycle.
                        uart_txd     <= 1'b0;
                    end
                end
                SEND: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= 16'd0;
                        if (bit_cnt == LAST_BIT) begin
                            state        <= IDLE;
                            bit_cnt      <= 4'd0;
                            uart_tx_busy <= 1'b0;
                            uart_tx_done <= 1'b1;
                            uart_txd     <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            // Register the next bit's level so txd changes exactly on the wrap.
                            uart_txd <= bit_value(bit_cnt + 4'd1, data_reg);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    localparam int BIT_CYC = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_txd;
    logic       uart_tx_busy;
    logic       uart_tx_done;

    int errors = 0;
    int checks = 0;

    uart_tx #(.CLK_FREQ(50000000), .UART_BPS(115200)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_txd     (uart_txd),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_done (uart_tx_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Called at a negedge; requests data d and checks the whole frame cycle by
    // cycle. If inj >= 0, a second request with inj_data is raised on that
    // frame cycle. Returns at the negedge of the done cycle.
    task automatic run_frame(input logic [7:0] d, input string nm,
                             input int inj, input logic [7:0] inj_data);
        logic [10:0] bits;
        int bad_bit, bad_busy, bad_done, cyc;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^d;
`endif
        uart_tx_data = d;
        uart_tx_en   = 1'b1;
        bad_busy = 0;
        bad_done = 0;
        cyc = 0;
        for (int b = 0; b < NBITS; b++) begin
            bad_bit = 0;
            for (int c = 0; c < BIT_CYC; c++) begin
                @(negedge clk);
                cyc++;
                uart_tx_en = (cyc == inj);
                if (cyc == inj) uart_tx_data = inj_data;
                if (uart_txd !== bits[b]) bad_bit++;
                if (uart_tx_busy !== 1'b1) bad_busy++;
                if (uart_tx_done !== 1'b0) bad_done++;
            end
            checks++;
            if (bad_bit != 0) begin
                errors++;
                $display("FAIL %s bit%0d: %0d cycles off, required level %b", nm, b, bad_bit, bits[b]);
            end
        end
        checks++;
        if (bad_busy != 0 || bad_done != 0) begin
            errors++;
            $display("FAIL %s busy/done in frame: busy bad %0d done bad %0d, required 0 0", nm, bad_busy, bad_done);
        end
        uart_tx_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({uart_tx_done, uart_tx_busy, uart_txd} !== 3'b101) begin
            errors++;
            $display("FAIL %s end: done,busy,txd=%b required 101", nm, {uart_tx_done, uart_tx_busy, uart_txd});
        end
    endtask

    task automatic check_idle(input int n, input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ({uart_tx_done, uart_tx_busy, uart_txd} !== 3'b001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s idle: %0d bad cycles, required done,busy,txd=001", nm, bad);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        uart_tx_en = 1'b0;
        uart_tx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({uart_tx_done, uart_tx_busy, uart_txd} !== 3'b001) begin
            errors++;
            $display("FAIL reset: done,busy,txd=%b required 001", {uart_tx_done, uart_tx_busy, uart_txd});
        end
        rst_n = 1'b1;
        check_idle(1000, "post_reset");
    endtask

    task automatic test_basic;
        run_frame(8'h55, "tx55", -1, 8'h00);
        check_idle(1, "after55");
        run_frame(8'h00, "tx00", -1, 8'h00);
        check_idle(5, "after00");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        run_frame(8'hA3, "txA3_par", -1, 8'h00);
        check_idle(5, "afterA3");
    endtask
`endif

    task automatic test_ignore_busy;
        run_frame(8'h0F, "tx0F_ign", 2000, 8'hFF);
        check_idle(20, "ignoredFF");
    endtask

    task automatic test_back_to_back;
        run_frame(8'h12, "b2b_12", -1, 8'h00);
        // Request issued in the done cycle; run_frame checks the start bit
        // on the very next cycle.
        run_frame(8'h34, "b2b_34", -1, 8'h00);
        check_idle(5, "after34");
    endtask

    task automatic test_reset_mid_frame;
        int bad;
        uart_tx_data = 8'h99;
        uart_tx_en   = 1'b1;
        @(negedge clk);
        uart_tx_en = 1'b0;
        repeat (1499) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b0 || uart_tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre: txd,busy=%b%b required 01", uart_txd, uart_tx_busy);
        end
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async: txd,busy=%b%b required 10", uart_txd, uart_tx_busy);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if ({uart_tx_done, uart_tx_busy, uart_txd} !== 3'b001) bad++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if ({uart_tx_done, uart_tx_busy, uart_txd} !== 3'b001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_mid hold: %0d bad cycles, required done,busy,txd=001", bad);
        end
        run_frame(8'hC4, "txC4", -1, 8'h00);
        check_idle(5, "afterC4");
    endtask

    initial begin
        test_reset;
        test_basic;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter UART_BPS, default 115200, meaning the line baud rate.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port uart_tx_en, input, 1 bit, single-cycle transmit request.
REQ-006 The module SHALL have port uart_tx_data, input, 8 bits, the byte to send; sampled with uart_tx_en.
REQ-007 The module SHALL have port uart_txd, output, 1 bit, the serial line; idle high.
REQ-008 The module SHALL have port uart_tx_busy, output, 1 bit, high while a frame is in progress.
REQ-009 The module SHALL have port uart_tx_done, output, 1 bit, one-cycle pulse at frame end.

Function
REQ-010 The block SHALL compute localparam BAUD_CNT_MAX = CLK_FREQ / UART_BPS using integer division, giving 434 at default parameters; each bit SHALL last exactly BAUD_CNT_MAX clk cycles.
REQ-011 The block SHALL have two states: IDLE (busy=0) and SEND (busy=1).
REQ-012 In IDLE, uart_tx_en=1 SHALL latch uart_tx_data into an internal shift/hold register and enter SEND on the next edge.
REQ-013 A request while busy=1 SHALL be ignored; the latched byte SHALL not change mid-frame.
REQ-014 The frame SHALL be: start bit (0), data[0] through data[7] LSB first, then stop bit (1); 10 bits total without parity.
REQ-015 uart_txd SHALL drive the start bit from the first cycle of SEND, i.e. one cycle after the accepting edge.
REQ-016 A 16-bit baud counter SHALL count 0..BAUD_CNT_MAX-1 during SEND, and a 4-bit bit counter SHALL advance when the baud counter wraps.
REQ-017 On the final cycle of the stop bit (last bit index, baud counter = BAUD_CNT_MAX-1), the next edge SHALL return the block to IDLE with busy=0, done=1 for exactly one cycle, and uart_txd=1.
REQ-018 uart_tx_en asserted in the cycle in which uart_tx_done=1 SHALL be accepted (back-to-back frames), leaving exactly one idle-high cycle between the stop bit and the next start bit.
REQ-019 uart_txd SHALL be a registered output, glitch-free, and held at 1 throughout IDLE.
REQ-020 Both counters SHALL be held at 0 in IDLE.

Reset
REQ-021 While rst_n=0, uart_txd SHALL be 1, uart_tx_busy SHALL be 0, uart_tx_done SHALL be 0, all counters SHALL be 0, the data register SHALL be 0, and the state SHALL be IDLE.
REQ-022 Reset asserted mid-frame SHALL immediately (asynchronously) force uart_txd=1 and abort the frame; no done pulse SHALL be issued.
REQ-023 After rst_n deasserts, the first request SHALL be accepted on the first rising edge on which it is asserted.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined SHALL insert an even parity bit (XOR of the 8 data bits) between data[7] and the stop bit, making an 11-bit frame and making the last bit index 10.
REQ-025 Macro UART_TX_PARITY_EN undefined SHALL produce the 10-bit frame of REQ-014 with no parity logic present.

Verification (CLK_FREQ=50000000, UART_BPS=115200, 434 cycles/bit)
REQ-026 Scenario: reset, then idle for 1000 cycles -> uart_txd=1, busy=0, and done=0 throughout.
REQ-027 Scenario: pulse tx_en with data 8'h55 -> txd line reads 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles; busy high for 4340 cycles; one done pulse.
REQ-028 Scenario: send 8'hA3 with parity enabled -> data bits 1,1,0,0,0,1,0,1, then parity bit 0 and stop bit 1; frame length 4774 cycles.
REQ-029 Scenario: send 8'h0F with tx_en reasserted with 8'hFF at cycle 2000 of the frame -> the second request is ignored; only 8'h0F is transmitted.
REQ-030 Scenario: send 8'h12 and 8'h34 back-to-back, the second tx_en coincident with done -> start bit of the second frame begins one cycle after done; both bytes are decoded correctly by a bench UART model.
REQ-031 Scenario: assert rst_n=0 at cycle 1500 of a frame -> txd=1 within the same cycle; after release, a new frame with 8'hC4 is transmitted correctly.
